traffic_light_ctrl: RTL and testbench
=====================================

// Module: traffic_light_ctrl
// PURPOSE
//  Two-road (NS/EW) traffic-light sequencer with pedestrian walk phase. Consumer of the
//  divided slow clock: samples tick_in (1 Hz square wave from the clock divider) in the
//  clk_in domain and uses each rising edge as a one-second timebase.
//  Drives the lamp outputs on the board. Uses no derived clock.
// PARAMETERS
//  GREEN_S      10  green duration per road, in seconds (1..255)
//  YELLOW_S      3  yellow duration, seconds (1..255)
//  ALLRED_S      1  all-red clearance duration, seconds (1..255)
//  WALK_S        5  pedestrian walk duration, seconds (1..255)
//  MIN_GREEN_S   4  minimum green before a ped request may cut green (1..GREEN_S)
// PORTS
//  clk_in    in   1  system clock (50 MHz); the only clock
//  rst_n     in   1  asynchronous active-low reset
//  tick_in   in   1  slow square wave from divider; treated as asynchronous
//  ped_req   in   1  pedestrian button level, asynchronous
//  ns_red    out  1  NS red lamp
//  ns_yel    out  1  NS yellow lamp
//  ns_grn    out  1  NS green lamp
//  ew_red    out  1  EW red lamp
//  ew_yel    out  1  EW yellow lamp
//  ew_grn    out  1  EW green lamp
//  ped_walk  out  1  walk lamp
//  ped_wait  out  1  request-pending lamp
// BEHAVIOUR
//  - Sync: tick_in and ped_req each pass through 2 flops, plus 1 edge-detect flop.
//    sec_pulse is high for 1 clk_in cycle, 3 clk_in edges after a tick_in rise.
//    A falling edge, or tick_in held high, produces no pulse.
//  - ped_pending: set on a synchronized ped_req rising edge and cleared on entry to WALK.
//    Set has priority when both occur in the same cycle. ped_wait = ped_pending.
//  - States: ALLRED_A -> NS_GRN -> NS_YEL -> ALLRED_B -> EW_GRN -> EW_YEL -> ALLRED_A.
//    From ALLRED_A or ALLRED_B, if ped_pending: go to WALK, then WALK goes to the green
//    that would have followed (ALLRED_A -> NS_GRN, ALLRED_B -> EW_GRN).
//  - Timer: 8-bit, cleared on every state entry. On sec_pulse: if timer == DUR-1, change
//    state and clear the timer; otherwise timer + 1. Each state therefore lasts exactly
//    DUR sec_pulses. Without sec_pulse the timer and state hold.
//  - Green cut: in NS_GRN or EW_GRN, on sec_pulse with ped_pending=1 and timer >=
//    MIN_GREEN_S-1, go to that road's yellow. The normal GREEN_S expiry still applies.
//  - Outputs: registered Moore decode of the state; they change on the same edge as the
//    state register.
//      ALLRED*/WALK: both reds = 1; ped_walk = 1 only in WALK.
//      x_GRN: x_grn = 1, other road red = 1.   x_YEL: x_yel = 1, other road red = 1.
//    Exactly one lamp per road is on at all times. ns_grn and ew_grn are never both 1.
//  - Reset: state = ALLRED_A, timer = 0, ped_pending = 0, all sync flops = 0.
//    Outputs on reset: ns_red = ew_red = 1, all other outputs 0.
//    Reset takes effect mid-phase, immediately and asynchronously.
//  - Illegal or unused state encodings recover to ALLRED_A on the next clock.
// TESTING
//  1. Defaults, tick_in toggling every 8 clk_in, no ped. Required sequence, in sec_pulses:
//     ALLRED_A 1, NS_GRN 10, NS_YEL 3, ALLRED_B 1, EW_GRN 10, EW_YEL 3, then repeat.
//  2. Single tick_in rise -> sec_pulse exactly 3 clk_in later, 1 cycle wide.
//     tick_in fall, or tick_in held high for 100 cycles -> no pulse.
//  3. ped_req pulse in NS_GRN at timer = 1 -> ped_wait = 1 within 3 clk.
//     NS_GRN then lasts 4 pulses total, followed by NS_YEL 3, ALLRED_B 1, WALK 5
//     (ped_walk = 1, ped_wait drops on WALK entry), then EW_GRN.
//  4. ped_req in EW_GRN at timer = 7 -> EW_YEL entered on the next sec_pulse.
//  5. ped_req during WALK -> ped_wait stays 1. A second WALK follows the next ALLRED phase.
//     Also: a ped edge in the same cycle as WALK entry leaves ped_wait = 1.
//  6. rst_n low mid EW_GRN -> outputs show both reds only, with no clock edge needed.
//     After release, the step-1 sequence restarts from ALLRED_A.
//     Assertion over all tests: never ns_grn & ew_grn, never two lamps on one road.

Source files
------------

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic-light sequencer with pedestrian walk phase, timed off a
// synchronized 1 Hz tick sampled in the clk_in domain.
module traffic_light_ctrl #(
  parameter int GREEN_S     = 10,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 1,
  parameter int WALK_S      = 5,
  parameter int MIN_GREEN_S = 4
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic tick_in,
  input  logic ped_req,
  output logic ns_red,
  output logic ns_yel,
  output logic ns_grn,
  output logic ew_red,
  output logic ew_yel,
  output logic ew_grn,
  output logic ped_walk,
  output logic ped_wait
);

  typedef enum logic [2:0] {
    ALLRED_A = 3'd0,
    NS_GRN   = 3'd1,
    NS_YEL   = 3'd2,
    ALLRED_B = 3'd3,
    EW_GRN   = 3'd4,
    EW_YEL   = 3'd5,
    WALK     = 3'd6
  } state_t;

  localparam logic [7:0] GRN_T = 8'(GREEN_S);
  localparam logic [7:0] YEL_T = 8'(YELLOW_S);
  localparam logic [7:0] ARD_T = 8'(ALLRED_S);
  localparam logic [7:0] WLK_T = 8'(WALK_S);
  localparam logic [7:0] CUT_T = 8'(MIN_GREEN_S - 1);

  // lamp vector order: ns r/y/g, ew r/y/g, walk
  localparam logic [6:0] L_ALLRED = 7'b100_100_0;

  state_t     state_q, state_n;
  logic [7:0] timer_q, timer_n, dur;
  logic       tick_s1, tick_s2, tick_d;
  logic       ped_s1, ped_s2, ped_d;
  logic       sec_pulse, ped_edge, expire, cut, walk_entry;
  logic       pend_q, pend_n;
  logic       walk_ew_q, walk_ew_n;
  logic [6:0] lamp_q, lamp_n;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_d  <= 1'b0;
      ped_s1  <= 1'b0;
      ped_s2  <= 1'b0;
      ped_d   <= 1'b0;
    end else begin
      tick_s1 <= tick_in;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
      ped_s1  <= ped_req;
      ped_s2  <= ped_s1;
      ped_d   <= ped_s2;
    end
  end

  assign sec_pulse = tick_s2 & ~tick_d;
  assign ped_edge  = ped_s2 & ~ped_d;

  always_comb begin
    dur = ARD_T;
    case (state_q)
      NS_GRN, EW_GRN: dur = GRN_T;
      NS_YEL, EW_YEL: dur = YEL_T;
      WALK:           dur = WLK_T;
      default:        dur = ARD_T;
    endcase
  end

  assign expire = sec_pulse && (timer_q == dur - 8'd1);
  assign cut    = sec_pulse && pend_q && (timer_q >= CUT_T);

  always_comb begin
    state_n = state_q;
    case (state_q)
      ALLRED_A: if (expire) state_n = pend_q ? WALK : NS_GRN;
      NS_GRN:   if (expire || cut) state_n = NS_YEL;
      NS_YEL:   if (expire) state_n = ALLRED_B;
      ALLRED_B: if (expire) state_n = pend_q ? WALK : EW_GRN;
      EW_GRN:   if (expire || cut) state_n = EW_YEL;
      EW_YEL:   if (expire) state_n = ALLRED_A;
      WALK:     if (expire) state_n = walk_ew_q ? EW_GRN : NS_GRN;
      default:  state_n = ALLRED_A;
    endcase
  end

  always_comb begin
    timer_n = timer_q;
    if (state_n != state_q) timer_n = 8'd0;
    else if (sec_pulse)     timer_n = timer_q + 8'd1;
  end

  // Remember which all-red led into WALK so WALK resumes the right road.
  always_comb begin
    walk_ew_n = walk_ew_q;
    if (state_n == WALK && state_q == ALLRED_B) walk_ew_n = 1'b1;
    else if (state_n == WALK && state_q == ALLRED_A) walk_ew_n = 1'b0;
  end

  assign walk_entry = (state_n == WALK) && (state_q != WALK);
  assign pend_n     = ped_edge | (pend_q & ~walk_entry);

  always_comb begin
    lamp_n = L_ALLRED;
    case (state_n)
      NS_GRN:  lamp_n = 7'b001_100_0;
      NS_YEL:  lamp_n = 7'b010_100_0;
      EW_GRN:  lamp_n = 7'b100_001_0;
      EW_YEL:  lamp_n = 7'b100_010_0;
      WALK:    lamp_n = 7'b100_100_1;
      default: lamp_n = L_ALLRED;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ALLRED_A;
      timer_q   <= 8'd0;
      pend_q    <= 1'b0;
      walk_ew_q <= 1'b0;
      lamp_q    <= L_ALLRED;
    end else begin
      state_q   <= state_n;
      timer_q   <= timer_n;
      pend_q    <= pend_n;
      walk_ew_q <= walk_ew_n;
      lamp_q    <= lamp_n;
    end
  end

  assign {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, ped_walk} = lamp_q;
  assign ped_wait = pend_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl: directed phase-timing scenarios plus random
// tick/ped stimulus against a seconds-counting reference model.
module tb_traffic_light_ctrl;

  localparam int MIN_G = 4;
  localparam logic [6:0] P_AR  = 7'b100_100_0;
  localparam logic [6:0] P_NSG = 7'b001_100_0;
  localparam logic [6:0] P_NSY = 7'b010_100_0;
  localparam logic [6:0] P_EWG = 7'b100_001_0;
  localparam logic [6:0] P_EWY = 7'b100_010_0;
  localparam logic [6:0] P_WLK = 7'b100_100_1;

  logic clk_in = 1'b0, rst_n = 1'b0, ped_req = 1'b0;
  logic tick_gen = 1'b0, tick_man = 1'b0, tick_in;
  bit   tick_en = 1'b0;
  int   half = 8, tcnt = 0;
  logic ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, ped_walk, ped_wait;

  int total = 0, bad = 0;
  int cyc = 0, seg_start = 0, chg_cnt = 0, last_len = 0;
  logic [6:0] prev_lv = P_AR, last_pat = P_AR;

  traffic_light_ctrl dut (
    .clk_in(clk_in), .rst_n(rst_n), .tick_in(tick_in), .ped_req(ped_req),
    .ns_red(ns_red), .ns_yel(ns_yel), .ns_grn(ns_grn),
    .ew_red(ew_red), .ew_yel(ew_yel), .ew_grn(ew_grn),
    .ped_walk(ped_walk), .ped_wait(ped_wait)
  );

  wire [6:0] lv = {ns_red, ns_yel, ns_grn, ew_red, ew_yel, ew_grn, ped_walk};
  assign tick_in = tick_en ? tick_gen : tick_man;

  always #5 clk_in = ~clk_in;

  // square-wave tick source, half period in clk_in cycles
  initial forever begin
    @(posedge clk_in); #1;
    if (!tick_en) begin tick_gen = 1'b0; tcnt = 0; end
    else begin
      tcnt++;
      if (tcnt >= half) begin tick_gen = ~tick_gen; tcnt = 0; end
    end
  end

  // Reference model: phase 0..6 = AR_A,NSG,NSY,AR_B,EWG,EWY,WALK; m_el counts
  // seconds spent in the phase. A level seen 2 edges ago but not 3 edges ago is a
  // rise that acts on this edge.
  int  dur_of[7] = '{1, 10, 3, 1, 10, 3, 5};
  int  m_ph = 0, m_el = 0, m_after = 1;
  bit  m_pend = 1'b0, mp, mpe;
  bit [2:0] th = 3'b0, phh = 3'b0;

  initial forever begin
    @(posedge clk_in or negedge rst_n);
    if (!rst_n) begin
      m_ph = 0; m_el = 0; m_pend = 1'b0; m_after = 1; th = 3'b0; phh = 3'b0;
    end else begin
      mp  = th[1] && !th[2];
      mpe = phh[1] && !phh[2];
      if (mp) begin
        if ((m_ph == 1 || m_ph == 4) && m_pend && m_el >= MIN_G - 1) begin
          m_ph = m_ph + 1; m_el = 0;
        end else if (m_el == dur_of[m_ph] - 1) begin
          m_el = 0;
          if ((m_ph == 0 || m_ph == 3) && m_pend) begin
            m_after = m_ph + 1; m_ph = 6; m_pend = 1'b0;
          end else if (m_ph == 6) m_ph = m_after;
          else m_ph = (m_ph + 1) % 6;
        end else m_el++;
      end
      if (mpe) m_pend = 1'b1;
      th  = {th[1:0], tick_in};
      phh = {phh[1:0], ped_req};
    end
  end

  function automatic logic [6:0] lamps_of(int p);
    case (p)
      1: return P_NSG;
      2: return P_NSY;
      4: return P_EWG;
      5: return P_EWY;
      6: return P_WLK;
      default: return P_AR;
    endcase
  endfunction

  // segment tracker and lamp-legality monitor
  initial forever begin
    @(negedge clk_in);
    cyc++;
    if (lv != prev_lv) begin
      last_pat = prev_lv; last_len = cyc - seg_start;
      seg_start = cyc; prev_lv = lv; chg_cnt++;
    end
    total++;
    if ((ns_grn && ew_grn) || $countones({ns_red, ns_yel, ns_grn}) != 1 ||
        $countones({ew_red, ew_yel, ew_grn}) != 1) begin
      bad++;
      $display("FAIL lamp_legal: lamps=%b at cyc %0d", lv, cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic wait_change(input int limit, output logic [6:0] pat, output int len,
                             output bit ok);
    int c0 = chg_cnt;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_in); #1;
      if (chg_cnt != c0) break;
    end
    ok = (chg_cnt != c0); pat = last_pat; len = last_len;
  endtask

  task automatic wait_model(input int ph, input int el, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_in); #1;
      if (m_ph == ph && m_el == el) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in); #2;
    rst_n = 1'b0; tick_en = 1'b0; tick_man = 1'b0; ped_req = 1'b0; half = 8;
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
  endtask

  task automatic man_tick();
    @(posedge clk_in); #1 tick_man = 1'b1;
    repeat (4) @(posedge clk_in); #1 tick_man = 1'b0;
    repeat (4) @(posedge clk_in);
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (lv !== P_AR || ped_wait !== 1'b0) begin
      bad++; $display("FAIL reset_out: lamps=%b wait=%b want %b/0", lv, ped_wait, P_AR);
    end
    @(posedge clk_in); #1 rst_n = 1'b1;
  endtask

  task automatic test_seq();
    logic [6:0] exp_p[7] = '{P_NSG, P_NSY, P_AR, P_EWG, P_EWY, P_AR, P_NSG};
    int         exp_l[7] = '{160, 48, 16, 160, 48, 16, 160};
    logic [6:0] pat; int len; bit ok;
    do_reset(); tick_en = 1'b1;
    wait_change(400, pat, len, ok);
    total++;
    if (!ok || pat !== P_AR) begin bad++; $display("FAIL seq_first: pat=%b want %b ok=%0d", pat, P_AR, ok); end
    for (int i = 0; i < 7; i++) begin
      wait_change(400, pat, len, ok);
      total++;
      if (!ok || pat !== exp_p[i] || len != exp_l[i]) begin
        bad++; $display("FAIL seq_seg%0d: pat=%b len=%0d want %b/%0d", i, pat, len, exp_p[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_sync();
    int c0;
    do_reset();
    repeat (10) @(posedge clk_in);
    #1 tick_man = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk_in); @(negedge clk_in);
      total++;
      if (lv !== (k < 3 ? P_AR : P_NSG)) begin
        bad++; $display("FAIL sync_lat edge%0d: lamps=%b want %b", k, lv, k < 3 ? P_AR : P_NSG);
      end
    end
    c0 = chg_cnt;
    repeat (100) @(posedge clk_in);
    #1 tick_man = 1'b0;
    repeat (20) @(posedge clk_in);
    @(negedge clk_in); #1;
    total++;
    if (lv !== P_NSG || chg_cnt != c0) begin
      bad++; $display("FAIL sync_hold: lamps=%b changes=%0d want %b/0", lv, chg_cnt - c0, P_NSG);
    end
    // one pulse per rise: 9 more rises keep green, the 10th ends it
    repeat (9) man_tick();
    total++;
    if (lv !== P_NSG) begin bad++; $display("FAIL sync_width9: lamps=%b want %b", lv, P_NSG); end
    man_tick();
    total++;
    if (lv !== P_NSY) begin bad++; $display("FAIL sync_width10: lamps=%b want %b", lv, P_NSY); end
  endtask

  task automatic test_ped_cut();
    logic [6:0] exp_p[4] = '{P_NSG, P_NSY, P_AR, P_WLK};
    int         exp_l[4] = '{64, 48, 16, 80};
    logic [6:0] pat; int len; bit ok;
    do_reset(); tick_en = 1'b1;
    wait_model(1, 1, 400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL cut_reach: model never reached NS_GRN t=1"); end
    ped_req = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if (ped_wait !== 1'b1) begin bad++; $display("FAIL cut_wait: ped_wait=%b want 1", ped_wait); end
    ped_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_change(400, pat, len, ok);
      total++;
      if (!ok || pat !== exp_p[i] || len != exp_l[i]) begin
        bad++; $display("FAIL cut_seg%0d: pat=%b len=%0d want %b/%0d", i, pat, len, exp_p[i], exp_l[i]);
      end
      if (i == 2) begin
        total++;
        if (ped_wait !== 1'b0 || ped_walk !== 1'b1) begin
          bad++; $display("FAIL cut_walk_entry: wait=%b walk=%b want 0/1", ped_wait, ped_walk);
        end
      end
    end
    total++;
    if (lv !== P_EWG) begin bad++; $display("FAIL cut_after: lamps=%b want %b", lv, P_EWG); end
  endtask

  task automatic test_ped_ew();
    logic [6:0] exp_p[4] = '{P_EWG, P_EWY, P_AR, P_WLK};
    int         exp_l[4] = '{128, 48, 16, 80};
    logic [6:0] pat; int len; bit ok;
    wait_model(4, 7, 400, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ew_reach: model never reached EW_GRN t=7"); end
    ped_req = 1'b1; repeat (2) @(posedge clk_in); #1 ped_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_change(400, pat, len, ok);
      total++;
      if (!ok || pat !== exp_p[i] || len != exp_l[i]) begin
        bad++; $display("FAIL ew_seg%0d: pat=%b len=%0d want %b/%0d", i, pat, len, exp_p[i], exp_l[i]);
      end
    end
    total++;
    if (lv !== P_NSG) begin bad++; $display("FAIL ew_after: lamps=%b want %b", lv, P_NSG); end
  endtask

  task automatic test_ped_walk();
    logic [6:0] exp_p[4] = '{P_WLK, P_NSG, P_NSY, P_AR};
    int         exp_l[4] = '{80, 64, 48, 16};
    logic [6:0] pat; int len; bit ok;
    do_reset(); tick_en = 1'b1;
    ped_req = 1'b1; repeat (2) @(posedge clk_in); #1 ped_req = 1'b0;
    wait_change(400, pat, len, ok);
    total++;
    if (!ok || pat !== P_AR || lv !== P_WLK) begin
      bad++; $display("FAIL walk_first: pat=%b now=%b want %b then %b", pat, lv, P_AR, P_WLK);
    end
    repeat (20) @(posedge clk_in);
    #1 ped_req = 1'b1; repeat (3) @(posedge clk_in); #1 ped_req = 1'b0;
    @(negedge clk_in);
    total++;
    if (ped_wait !== 1'b1) begin bad++; $display("FAIL walk_req: ped_wait=%b want 1", ped_wait); end
    for (int i = 0; i < 4; i++) begin
      wait_change(400, pat, len, ok);
      total++;
      if (!ok || pat !== exp_p[i] || len != exp_l[i]) begin
        bad++; $display("FAIL walk_seg%0d: pat=%b len=%0d want %b/%0d", i, pat, len, exp_p[i], exp_l[i]);
      end
    end
    total++;
    if (lv !== P_WLK) begin bad++; $display("FAIL walk_second: lamps=%b want %b", lv, P_WLK); end

    // ped edge landing on the same edge as WALK entry
    do_reset();
    ped_req = 1'b1; repeat (3) @(posedge clk_in); #1 ped_req = 1'b0;
    repeat (5) @(posedge clk_in);
    #1 begin tick_man = 1'b1; ped_req = 1'b1; end
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    total++;
    if (lv !== P_WLK || ped_wait !== 1'b1) begin
      bad++; $display("FAIL walk_same_edge: lamps=%b wait=%b want %b/1", lv, ped_wait, P_WLK);
    end
    ped_req = 1'b0; tick_man = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [6:0] exp_p[4] = '{P_AR, P_NSG, P_NSY, P_AR};
    int         exp_l[3] = '{160, 48, 16};
    logic [6:0] pat; int len; bit ok;
    do_reset(); tick_en = 1'b1;
    wait_model(4, 3, 1000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL ar_reach: model never reached EW_GRN t=3"); end
    ped_req = 1'b1; repeat (4) @(posedge clk_in); #1 ped_req = 1'b0;
    @(negedge clk_in); #3 rst_n = 1'b0;
    #1;
    total++;
    if (lv !== P_AR || ped_wait !== 1'b0) begin
      bad++; $display("FAIL ar_async: lamps=%b wait=%b want %b/0", lv, ped_wait, P_AR);
    end
    tick_en = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1; tick_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_change(400, pat, len, ok);
      total++;
      if (!ok || pat !== exp_p[i] || (i > 0 && len != exp_l[i-1])) begin
        bad++; $display("FAIL ar_seg%0d: pat=%b len=%0d want %b", i, pat, len, exp_p[i]);
      end
    end
  endtask

  task automatic test_random();
    do_reset(); tick_en = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_in);
      total++;
      if (lv !== lamps_of(m_ph) || ped_wait !== m_pend) begin
        bad++; $display("FAIL rand cyc%0d: lamps=%b wait=%b want %b/%b", i, lv, ped_wait, lamps_of(m_ph), m_pend);
      end
      if ($urandom_range(0, 149) == 0) ped_req = ~ped_req;
      if ($urandom_range(0, 199) == 0) half = $urandom_range(3, 12);
    end
    ped_req = 1'b0; half = 8;
  endtask

  initial begin
    test_reset();
    test_seq();
    test_sync();
    test_ped_cut();
    test_ped_ew();
    test_ped_walk();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
